// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - direct-mapped, one-word-per-line instruction cache between IF and the memory controller
module icache_fetch #(
   parameter int INDEX_BITS = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req_i,
   input  logic [31:0] fetch_pc_i,
   input  logic        flush_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        mem_inst_req_o,
   output logic [31:0] mem_inst_addr_o,
   input  logic [31:0] mem_inst_i,
   input  logic [31:0] mem_inst_pc_i,
   input  logic        mem_inst_done_i
);

   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int LINES    = 1 << INDEX_BITS;

   localparam logic S_IDLE = 1'b0;
   localparam logic S_MISS = 1'b1;

   logic                  state;
   logic [LINES-1:0]      valid;
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [31:0]           data_mem [LINES];

   logic [INDEX_BITS-1:0] fetch_idx;
   logic [TAG_BITS-1:0]   fetch_tag;
   logic [INDEX_BITS-1:0] miss_idx;
   logic                  hit;
   logic                  accept;
   logic                  fill;

   assign fetch_idx = fetch_pc_i[INDEX_BITS+1:2];
   assign fetch_tag = fetch_pc_i[31:INDEX_BITS+2];
   assign miss_idx  = mem_inst_addr_o[INDEX_BITS+1:2];

   assign hit    = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
   assign accept = (state == S_IDLE) && fetch_req_i && !flush_i;
   // Responses whose pc differs from the outstanding miss are stale and ignored.
   assign fill   = (state == S_MISS) && mem_inst_done_i && (mem_inst_pc_i == mem_inst_addr_o);

   // Dropped in the completion cycle so the controller does not start a new fetch.
   assign mem_inst_req_o = (state == S_MISS) && !fill;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= S_IDLE;
         valid           <= '0;
         inst_valid_o    <= 1'b0;
         inst_o          <= 32'h0;
         inst_pc_o       <= 32'h0;
         mem_inst_addr_o <= 32'h0;
      end else begin
         inst_valid_o <= 1'b0;
         if (fill) begin
            valid[miss_idx] <= 1'b1;
         end
         if (flush_i) begin
            state <= S_IDLE;
         end else if (fill) begin
            inst_valid_o <= 1'b1;
            inst_o       <= mem_inst_i;
            inst_pc_o    <= mem_inst_addr_o;
            state        <= S_IDLE;
         end else if (accept) begin
            if (hit) begin
               inst_valid_o <= 1'b1;
               inst_o       <= data_mem[fetch_idx];
               inst_pc_o    <= fetch_pc_i;
            end else begin
               mem_inst_addr_o <= {fetch_pc_i[31:2], 2'b00};
               state           <= S_MISS;
            end
         end
      end
   end

   // A completion coinciding with a flush still fills the line.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[miss_idx]  <= mem_inst_addr_o[31:INDEX_BITS+2];
         data_mem[miss_idx] <= mem_inst_i;
      end
   end

endmodule

// File: tb/tb_icache_fetch.sv
// tb/tb_icache_fetch.sv - directed self-checking bench for icache_fetch
module tb_icache_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        flush;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_inst;
   logic [31:0] mem_pc;
   logic        mem_done;

   int checks   = 0;
   int failures = 0;

   logic        first_req;
   logic [31:0] first_addr;
   logic        done_req;
   logic        got_v;
   logic [31:0] got_inst;
   logic [31:0] got_pc;

   always #5 clk = ~clk;

   icache_fetch #(.INDEX_BITS(7)) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_req_i     (fetch_req),
      .fetch_pc_i      (fetch_pc),
      .flush_i         (flush),
      .inst_valid_o    (inst_valid),
      .inst_o          (inst),
      .inst_pc_o       (inst_pc),
      .mem_inst_req_o  (mem_req),
      .mem_inst_addr_o (mem_addr),
      .mem_inst_i      (mem_inst),
      .mem_inst_pc_i   (mem_pc),
      .mem_inst_done_i (mem_done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full miss transaction with a 5-cycle controller; records observations for the caller.
   task automatic miss_fill(input logic [31:0] addr, input logic [31:0] data);
      fetch_req = 1'b1;
      fetch_pc  = addr;
      step();
      first_req  = mem_req;
      first_addr = mem_addr;
      repeat (4) step();
      mem_done = 1'b1;
      mem_inst = data;
      mem_pc   = addr;
      #1;
      done_req = mem_req;
      step();
      got_v    = inst_valid;
      got_inst = inst;
      got_pc   = inst_pc;
      fetch_req = 1'b0;
      mem_done  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; fetch_req = 1'b0; fetch_pc = 32'h0; flush = 1'b0;
      mem_inst = 32'h0; mem_pc = 32'h0; mem_done = 1'b0;
      repeat (2) step();
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=0", inst_valid); end
      checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst); end
      checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%h exp=0", mem_req); end
      rst = 1'b1;
      step();
      miss_fill(32'h0, 32'h0000_0013);
      checks++; if (got_v !== 1'b1 || got_inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_prefill got=%h/%h exp=1/00000013", got_v, got_inst); end
      fetch_req = 1'b1; fetch_pc = 32'h8;
      step();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_premiss_req got=%h exp=1", mem_req); end
      #3;
      rst = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%h exp=0", mem_req); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%h exp=0", inst_valid); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mid_addr got=%h exp=0", mem_addr); end
      fetch_req = 1'b0;
      step();
      rst = 1'b1;
      step();
      miss_fill(32'h0, 32'h0000_0013);
      checks++; if (first_req !== 1'b1) begin failures++; $display("FAIL rst_refetch_miss got=%h exp=1", first_req); end
      checks++; if (got_inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_refetch_inst got=%h exp=00000013", got_inst); end
   endtask

   task automatic test_cold_miss();
      miss_fill(32'h1000, 32'h0050_0093);
      checks++; if (first_req !== 1'b1) begin failures++; $display("FAIL cold_req got=%h exp=1", first_req); end
      checks++; if (first_addr !== 32'h1000) begin failures++; $display("FAIL cold_addr got=%h exp=00001000", first_addr); end
      checks++; if (done_req !== 1'b0) begin failures++; $display("FAIL cold_done_req got=%h exp=0", done_req); end
      checks++; if (got_v !== 1'b1) begin failures++; $display("FAIL cold_valid got=%h exp=1", got_v); end
      checks++; if (got_inst !== 32'h0050_0093) begin failures++; $display("FAIL cold_inst got=%h exp=00500093", got_inst); end
      checks++; if (got_pc !== 32'h1000) begin failures++; $display("FAIL cold_pc got=%h exp=00001000", got_pc); end
      step();
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL cold_single_pulse got=%h exp=0", inst_valid); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cold_idle_req got=%h exp=0", mem_req); end
   endtask

   task automatic test_hit_stream();
      miss_fill(32'h1004, 32'h0010_0113);
      checks++; if (got_inst !== 32'h0010_0113) begin failures++; $display("FAIL hs_fill got=%h exp=00100113", got_inst); end
      step();
      fetch_req = 1'b1; fetch_pc = 32'h1000;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hs_req0 got=%h exp=0", mem_req); end
      step();
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || inst_pc !== 32'h1000) begin failures++; $display("FAIL hs_hit0 got=%h/%h/%h exp=1/00500093/00001000", inst_valid, inst, inst_pc); end
      fetch_pc = 32'h1004;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hs_req1 got=%h exp=0", mem_req); end
      step();
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0113 || inst_pc !== 32'h1004) begin failures++; $display("FAIL hs_hit1 got=%h/%h/%h exp=1/00100113/00001004", inst_valid, inst, inst_pc); end
      fetch_req = 1'b0;
      step();
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL hs_end got=%h exp=0", inst_valid); end
   endtask

   task automatic test_conflict();
      miss_fill(32'h0, 32'h1111_1111);
      checks++; if (first_req !== 1'b1 || got_inst !== 32'h1111_1111) begin failures++; $display("FAIL cf_fill0 got=%h/%h exp=1/11111111", first_req, got_inst); end
      step();
      miss_fill(32'h200, 32'h2222_2222);
      checks++; if (first_req !== 1'b1) begin failures++; $display("FAIL cf_miss200 got=%h exp=1", first_req); end
      checks++; if (got_inst !== 32'h2222_2222 || got_pc !== 32'h200) begin failures++; $display("FAIL cf_out200 got=%h/%h exp=22222222/00000200", got_inst, got_pc); end
      step();
      miss_fill(32'h0, 32'h1111_1111);
      checks++; if (first_req !== 1'b1) begin failures++; $display("FAIL cf_remiss0 got=%h exp=1", first_req); end
      checks++; if (got_inst !== 32'h1111_1111 || got_pc !== 32'h0) begin failures++; $display("FAIL cf_out0 got=%h/%h exp=11111111/00000000", got_inst, got_pc); end
      step();
   endtask

   task automatic test_flush();
      fetch_req = 1'b1; fetch_pc = 32'h40;
      step();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin failures++; $display("FAIL fl_miss40 got=%h/%h exp=1/00000040", mem_req, mem_addr); end
      step();
      flush = 1'b1; fetch_pc = 32'h80;
      step();
      flush = 1'b0;
      mem_done = 1'b1; mem_inst = 32'hDEAD_BEEF; mem_pc = 32'h40;
      #1;
      checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL fl_after_flush got=%h/%h exp=0/0", inst_valid, mem_req); end
      step();
      mem_done = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fl_late_done got=%h exp=0", inst_valid); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin failures++; $display("FAIL fl_miss80 got=%h/%h exp=1/00000080", mem_req, mem_addr); end
      repeat (4) step();
      mem_done = 1'b1; mem_inst = 32'h0A0A_0A0A; mem_pc = 32'h80;
      step();
      mem_done = 1'b0; fetch_req = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h0A0A_0A0A || inst_pc !== 32'h80) begin failures++; $display("FAIL fl_out80 got=%h/%h/%h exp=1/0a0a0a0a/00000080", inst_valid, inst, inst_pc); end
      step();
      miss_fill(32'h40, 32'h4444_4444);
      checks++; if (first_req !== 1'b1 || got_inst !== 32'h4444_4444) begin failures++; $display("FAIL fl_40_unfilled got=%h/%h exp=1/44444444", first_req, got_inst); end
      step();
      // Completion coinciding with flush: line filled but not forwarded.
      fetch_req = 1'b1; fetch_pc = 32'h304;
      repeat (5) step();
      mem_done = 1'b1; mem_inst = 32'h3030_3030; mem_pc = 32'h304; flush = 1'b1;
      step();
      mem_done = 1'b0; flush = 1'b0; fetch_req = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fl_fill_suppressed got=%h exp=0", inst_valid); end
      step();
      fetch_req = 1'b1; fetch_pc = 32'h304;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fl_304_req got=%h exp=0", mem_req); end
      step();
      fetch_req = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h3030_3030) begin failures++; $display("FAIL fl_304_hit got=%h/%h exp=1/30303030", inst_valid, inst); end
      step();
   endtask

   task automatic test_stale();
      fetch_req = 1'b1; fetch_pc = 32'h100;
      step();
      repeat (2) step();
      mem_done = 1'b1; mem_inst = 32'hBAAD_F00D; mem_pc = 32'hFC;
      #1;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL st_req_stale got=%h exp=1", mem_req); end
      step();
      mem_done = 1'b0;
      checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b1) begin failures++; $display("FAIL st_still_miss got=%h/%h exp=0/1", inst_valid, mem_req); end
      step();
      mem_done = 1'b1; mem_inst = 32'h600D_0100; mem_pc = 32'h100;
      step();
      mem_done = 1'b0; fetch_req = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h600D_0100 || inst_pc !== 32'h100) begin failures++; $display("FAIL st_complete got=%h/%h/%h exp=1/600d0100/00000100", inst_valid, inst, inst_pc); end
      step();
      miss_fill(32'hFC, 32'h0000_00FC);
      checks++; if (first_req !== 1'b1 || got_inst !== 32'h0000_00FC) begin failures++; $display("FAIL st_fc_unfilled got=%h/%h exp=1/000000fc", first_req, got_inst); end
      step();
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit_stream();
      test_conflict();
      test_flush();
      test_stale();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
